// File: rtl/p20_uart_pkg.sv
// p20_uart_pkg
// Shared constants and types for the score-report UART.
//   DEFAULT_CLKS_PER_BIT : bit period in clocks (25.175 MHz / 115200)
//   CR, LF, SLASH, QMARK, ZERO : ASCII bytes used to build report frames
//   txState_e            : serializer state encoding
//   bcdToAscii()         : BCD digit to printable ASCII, '?' for non-decimal
package p20_uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 218;

  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] SLASH = 8'h2F;
  localparam logic [7:0] QMARK = 8'h3F;
  localparam logic [7:0] ZERO  = 8'h30;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } txState_e;

  // Nibbles 10..15 are not valid BCD; print them as '?' so a corrupted
  // score is visible on the terminal instead of turning into punctuation.
  function automatic logic [7:0] bcdToAscii(input logic [3:0] digit);
    if (digit <= 4'd9) begin
      return ZERO + {4'd0, digit};
    end
    return QMARK;
  endfunction

endpackage

// File: rtl/p20_uart_tx.sv
// p20_uart_tx
// 8N1 byte serializer, LSB first, line idles high.
// Ports:
//   clk_i    : system clock
//   rst_ni   : asynchronous active-low reset
//   valid_i  : a byte is offered on data_i
//   data_i   : byte to send
//   ready_o  : byte is taken when valid_i && ready_o; high in IDLE and on
//              the last cycle of STOP so bytes can run back-to-back
//   tx_o     : serial line
module p20_uart_tx
  import p20_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       tx_o
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  txState_e      state_q, state_d;
  logic [CW-1:0] clkCnt_q, clkCnt_d;
  logic [2:0]    bitCnt_q, bitCnt_d;
  logic [7:0]    shift_q, shift_d;

  logic bitDone;
  logic accept;

  // State, bit-time counter, data-bit counter and the byte being shifted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      clkCnt_q <= '0;
      bitCnt_q <= '0;
      shift_q  <= '0;
    end else begin
      state_q  <= state_d;
      clkCnt_q <= clkCnt_d;
      bitCnt_q <= bitCnt_d;
      shift_q  <= shift_d;
    end
  end

  // Next-state logic. The clock counter restarts at each bit boundary, so
  // every bit (start, data, stop) lasts exactly CLKS_PER_BIT cycles, and a
  // byte accepted on the final STOP cycle goes straight into START.
  always_comb begin
    state_d  = state_q;
    clkCnt_d = clkCnt_q;
    bitCnt_d = bitCnt_q;
    shift_d  = shift_q;

    bitDone = (clkCnt_q == CNT_LAST);
    ready_o = (state_q == IDLE) || ((state_q == STOP) && bitDone);
    accept  = valid_i && ready_o;

    if (state_q != IDLE) begin
      clkCnt_d = bitDone ? '0 : clkCnt_q + CW'(1);
    end

    case (state_q)
      IDLE: begin
        clkCnt_d = '0;
        bitCnt_d = '0;
        if (accept) begin
          state_d = START;
          shift_d = data_i;
        end
      end
      START: begin
        if (bitDone) begin
          state_d  = DATA;
          bitCnt_d = '0;
        end
      end
      DATA: begin
        if (bitDone) begin
          if (bitCnt_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bitCnt_d = bitCnt_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (bitDone) begin
          if (accept) begin
            state_d = START;
            shift_d = data_i;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level decodes only registered state, so reset drives it high
  // immediately and no input can glitch it.
  always_comb begin
    tx_o = 1'b1;
    case (state_q)
      START:   tx_o = 1'b0;
      DATA:    tx_o = shift_q[bitCnt_q];
      default: tx_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/p20_score_uart.sv
// p20_score_uart
// Sends the packed BCD score as ASCII over UART when the game halts.
// Ports:
//   clk       : system clock (25.175 MHz pixel clock)
//   sys_rst_n : asynchronous active-low reset
//   score_in  : packed BCD score, digit 3 in [15:12]
//   halt      : game-over level; its rising edge starts a report
//   game_rst  : new-game pulse, deliberately ignored (frames are never aborted)
//   tx        : UART output, 8N1, idle high
//   busy      : high while a report frame is on the line
// Build option: define P20_SCORE_UART_HISCORE_EN to track a high score and
// send "dddd/hhhh\r\n" instead of "dddd\r\n".
module p20_score_uart #(
  parameter int CLKS_PER_BIT = p20_uart_pkg::DEFAULT_CLKS_PER_BIT
) (
  input  logic        clk,
  input  logic        sys_rst_n,
  input  logic [15:0] score_in,
  input  logic        halt,
  input  logic        game_rst,
  output logic        tx,
  output logic        busy
);

  import p20_uart_pkg::*;

`ifdef P20_SCORE_UART_HISCORE_EN
  localparam int FRAME_LEN = 11;
`else
  localparam int FRAME_LEN = 6;
`endif
  localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

  logic        halt_q;
  logic        busy_q, busy_d;
  logic [3:0]  byteIdx_q, byteIdx_d;
  logic [15:0] score_q, score_d;
`ifdef P20_SCORE_UART_HISCORE_EN
  logic [15:0] hiscore_q, hiscore_d;
`endif

  logic       trigger;
  logic       startFrame;
  logic [3:0] nextIdx;
  logic [7:0] nextByte;
  logic       txValid;
  logic [7:0] txData;
  logic       txReady;
  logic       unusedGameRst;

  assign unusedGameRst = game_rst;
  assign busy          = busy_q;

  // halt_q resets high so a halt already asserted at reset release has to
  // drop and rise again before it reports.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      halt_q    <= 1'b1;
      busy_q    <= 1'b0;
      byteIdx_q <= '0;
      score_q   <= '0;
`ifdef P20_SCORE_UART_HISCORE_EN
      hiscore_q <= '0;
`endif
    end else begin
      halt_q    <= halt;
      busy_q    <= busy_d;
      byteIdx_q <= byteIdx_d;
      score_q   <= score_d;
`ifdef P20_SCORE_UART_HISCORE_EN
      hiscore_q <= hiscore_d;
`endif
    end
  end

  // Byte that follows the one currently on the line, built from the
  // latched score so mid-frame changes of score_in never show up.
  always_comb begin
    nextIdx  = byteIdx_q + 4'd1;
    nextByte = LF;
    case (nextIdx)
      4'd0: nextByte = bcdToAscii(score_q[15:12]);
      4'd1: nextByte = bcdToAscii(score_q[11:8]);
      4'd2: nextByte = bcdToAscii(score_q[7:4]);
      4'd3: nextByte = bcdToAscii(score_q[3:0]);
`ifdef P20_SCORE_UART_HISCORE_EN
      4'd4: nextByte = SLASH;
      4'd5: nextByte = bcdToAscii(hiscore_q[15:12]);
      4'd6: nextByte = bcdToAscii(hiscore_q[11:8]);
      4'd7: nextByte = bcdToAscii(hiscore_q[7:4]);
      4'd8: nextByte = bcdToAscii(hiscore_q[3:0]);
      4'd9: nextByte = CR;
`else
      4'd4: nextByte = CR;
`endif
      default: nextByte = LF;
    endcase
  end

  // Frame sequencing. The first byte is taken from score_in directly so
  // the start bit appears one edge after the trigger; afterwards each
  // ready pulse (last STOP cycle) either hands over the next byte or,
  // after the final byte, ends the frame on that same edge.
  always_comb begin
    busy_d    = busy_q;
    byteIdx_d = byteIdx_q;
    score_d   = score_q;
`ifdef P20_SCORE_UART_HISCORE_EN
    hiscore_d = hiscore_q;
`endif
    txValid   = 1'b0;
    txData    = '0;

    trigger    = halt && !halt_q;
    startFrame = trigger && !busy_q;

    if (startFrame) begin
      score_d   = score_in;
      busy_d    = 1'b1;
      byteIdx_d = '0;
      txValid   = 1'b1;
      txData    = bcdToAscii(score_in[15:12]);
`ifdef P20_SCORE_UART_HISCORE_EN
      if (score_in > hiscore_q) begin
        hiscore_d = score_in;
      end
`endif
    end else if (busy_q && txReady) begin
      if (byteIdx_q == LAST_IDX) begin
        busy_d    = 1'b0;
        byteIdx_d = '0;
      end else begin
        txValid   = 1'b1;
        txData    = nextByte;
        byteIdx_d = nextIdx;
      end
    end
  end

  p20_uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) uTx (
    .clk_i  (clk),
    .rst_ni (sys_rst_n),
    .valid_i(txValid),
    .data_i (txData),
    .ready_o(txReady),
    .tx_o   (tx)
  );

endmodule

// File: tb/tb_p20_score_uart.sv
// tb_p20_score_uart
// Directed bench for p20_score_uart with CLKS_PER_BIT = 4. Decodes the
// serial line and checks each frame byte, start latency, busy length,
// mid-frame re-trigger, reset truncation and halt-high-at-reset.
// Expected frames follow P20_SCORE_UART_HISCORE_EN when it is defined.
module tb_p20_score_uart;

  localparam int CPB = 4;

  logic        clk;
  logic        sys_rst_n;
  logic [15:0] score_in;
  logic        halt;
  logic        game_rst;
  logic        tx;
  logic        busy;

  int total;
  int bad;
  int busyCount;

  p20_score_uart #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk      (clk),
    .sys_rst_n(sys_rst_n),
    .score_in (score_in),
    .halt     (halt),
    .game_rst (game_rst),
    .tx       (tx),
    .busy     (busy)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts cycles with busy high, sampled mid-cycle
  initial busyCount = 0;
  always @(negedge clk) begin
    if (busy === 1'b1) busyCount <= busyCount + 1;
  end

  // Safety net in case a wait ever escapes its own bound
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] expByte(input string digits, input int i);
    if (i < digits.len()) return digits[i];
    if (i == digits.len()) return 8'h0D;
    return 8'h0A;
  endfunction

  // Drives a fresh halt rising edge with the given score and checks that
  // the start bit and busy appear one edge later. Returns busy count
  // snapshot taken while busy is still low.
  task automatic applyStimulus(input logic [15:0] sc, output int startCount);
    @(negedge clk);
    halt     = 1'b0;
    score_in = sc;
    @(negedge clk);
    halt = 1'b1;
    startCount = busyCount;
    @(negedge clk);
    checkOutput("latency_tx", {31'd0, tx}, 32'd0);
    checkOutput("latency_busy", {31'd0, busy}, 32'd1);
  endtask

  // Receives one byte. If detected is set, the caller is already on the
  // first mid-cycle sample of the start bit. ok is low on a missing start
  // bit or a bad stop bit.
  task automatic recvByte(input bit detected, output logic [7:0] b, output bit ok);
    b  = '0;
    ok = detected;
    if (!detected) begin
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (tx === 1'b0) begin
          ok = 1'b1;
          break;
        end
      end
    end
    if (!ok) return;
    repeat (CPB) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      b[k] = tx;
      repeat (CPB) @(negedge clk);
    end
    if (tx !== 1'b1) ok = 1'b0;
  endtask

  task automatic receiveBytes(input string tag, input string digits, input int from,
                              input int upto, input bit firstDetected);
    logic [7:0] b;
    bit ok;
    for (int i = from; i <= upto; i++) begin
      recvByte(firstDetected && (i == from), b, ok);
      checkOutput($sformatf("%s_byte%0d", tag, i), {23'd0, ok, b},
                  {23'd0, 1'b1, expByte(digits, i)});
    end
  endtask

  // Waits for busy to fall, then checks line idle and total busy time.
  task automatic finishFrame(input string tag, input int nBytes, input int startCount);
    bit dropped;
    dropped = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        dropped = 1'b1;
        break;
      end
    end
    checkOutput({tag, "_busy_drop"}, {31'd0, dropped}, 32'd1);
    checkOutput({tag, "_tx_idle"}, {31'd0, tx}, 32'd1);
    checkOutput({tag, "_busy_len"}, busyCount - startCount, nBytes * 10 * CPB);
  endtask

  initial begin
    string f1234, f0907, f00a5, f2222, f5678, f0150, f0042;
    logic [7:0] b;
    bit ok;
    bit found;
    int sc;
    int txLow;

`ifdef P20_SCORE_UART_HISCORE_EN
    f1234 = "1234/1234";
    f0907 = "0907/1234";
    f00a5 = "00?5/1234";
    f2222 = "2222/2222";
    f5678 = "5678/5678";
    f0150 = "0150/0150";
    f0042 = "0042/0150";
`else
    f1234 = "1234";
    f0907 = "0907";
    f00a5 = "00?5";
    f2222 = "2222";
    f5678 = "5678";
    f0150 = "0150";
    f0042 = "0042";
`endif

    total     = 0;
    bad       = 0;
    sys_rst_n = 1'b0;
    score_in  = '0;
    halt      = 1'b0;
    game_rst  = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset_tx", {31'd0, tx}, 32'd1);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    sys_rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Basic frame, busy exactly frame length; game_rst pulse mid-frame
    applyStimulus(16'h1234, sc);
    receiveBytes("f1234", f1234, 0, 0, 1'b1);
    game_rst = 1'b1;
    @(negedge clk);
    game_rst = 1'b0;
    receiveBytes("f1234", f1234, 1, f1234.len() + 1, 1'b0);
    finishFrame("f1234", f1234.len() + 2, sc);

    // New score and second halt edge mid-frame are ignored
    applyStimulus(16'h0907, sc);
    receiveBytes("f0907", f0907, 0, 0, 1'b1);
    @(negedge clk);
    halt = 1'b0;
    @(negedge clk);
    halt     = 1'b1;
    score_in = 16'h9999;
    receiveBytes("f0907", f0907, 1, f0907.len() + 1, 1'b0);
    finishFrame("f0907", f0907.len() + 2, sc);
    sc    = busyCount;
    txLow = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) txLow++;
    end
    checkOutput("no_second_frame_tx", txLow, 0);
    checkOutput("no_second_frame_busy", busyCount - sc, 0);

    // Non-decimal digit prints as '?'
    applyStimulus(16'h00A5, sc);
    receiveBytes("f00a5", f00a5, 0, f00a5.len() + 1, 1'b1);
    finishFrame("f00a5", f00a5.len() + 2, sc);

    // Reset during the start bit of byte 2 forces idle line at once
    applyStimulus(16'h2222, sc);
    receiveBytes("f2222", f2222, 0, 1, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("rst_byte2_start", {31'd0, found}, 32'd1);
    sys_rst_n = 1'b0;
    #1;
    checkOutput("rst_async_tx", {31'd0, tx}, 32'd1);
    checkOutput("rst_async_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    sys_rst_n = 1'b1;

    // Full frame after the truncated one
    applyStimulus(16'h5678, sc);
    receiveBytes("f5678", f5678, 0, f5678.len() + 1, 1'b1);
    finishFrame("f5678", f5678.len() + 2, sc);

    // halt still high through reset release: nothing until it re-rises
    @(negedge clk);
    sys_rst_n = 1'b0;
    @(negedge clk);
    sys_rst_n = 1'b1;
    sc    = busyCount;
    txLow = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) txLow++;
    end
    checkOutput("halt_high_rst_tx", txLow, 0);
    checkOutput("halt_high_rst_busy", busyCount - sc, 0);

    // High score rises then holds (plain frames when option is off)
    applyStimulus(16'h0150, sc);
    receiveBytes("f0150", f0150, 0, f0150.len() + 1, 1'b1);
    finishFrame("f0150", f0150.len() + 2, sc);

    applyStimulus(16'h0042, sc);
    receiveBytes("f0042", f0042, 0, f0042.len() + 1, 1'b1);
    finishFrame("f0042", f0042.len() + 2, sc);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
